// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width derivation for the synchronous FIFO.
package sync_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;

    // Pointer width needed to address every entry of a power-of-two deep FIFO.
    function automatic int addr_width_f(input int depth);
        return $clog2(depth);
    endfunction

    localparam int ADDR_WIDTH_DEF = addr_width_f(DEPTH_DEF);

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: one synchronous write port, one synchronous read port.
// The array and the read register carry no reset; the controller masks the
// read register until the first read after reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = addr_width_f(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Store the write word at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Capture the addressed entry on an accepted read; hold otherwise.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO controller: pointers, occupancy count and status flags.
// Optional half_full output is compiled in with SYNC_FIFO_HALFFULL_EN.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_enable,
    input  logic                  r_enable,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty
`ifdef SYNC_FIFO_HALFFULL_EN
    ,
    output logic                  half_full
`endif
);

    localparam int ADDR_WIDTH = addr_width_f(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = (ADDR_WIDTH)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = (ADDR_WIDTH)'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
`ifdef SYNC_FIFO_HALFFULL_EN
    localparam logic [ADDR_WIDTH:0]   CNT_HALF = (ADDR_WIDTH+1)'(DEPTH / 2);
`endif

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  rd_valid_r;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic [DATA_WIDTH-1:0] mem_rd_data_s;

    // Status flags decode registered count only, so inputs never reach them.
    always_comb begin
        full  = (count_r == CNT_FULL);
        empty = (count_r == CNT_ZERO);
    end

`ifdef SYNC_FIFO_HALFFULL_EN
    // Half-full decode from the registered count.
    always_comb begin
        half_full = (count_r >= CNT_HALF);
    end
`endif

    // A request is accepted only when its flag permits it; a full FIFO drops
    // a write even if a read frees a slot on the same edge.
    always_comb begin
        wr_accept_s = w_enable & ~full;
        rd_accept_s = r_enable & ~empty;
    end

    // Pointer, count and read-data-valid state; reset discards all entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_accept_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                rd_valid_r <= 1'b1;
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Read data is zero from reset until the first accepted read, then holds
    // the storage read register, which only changes on accepted reads.
    always_comb begin
        if (rd_valid_r) begin
            r_data = mem_rd_data_s;
        end else begin
            r_data = {DATA_WIDTH{1'b0}};
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept_s),
        .wr_addr (wr_ptr_r),
        .wr_data (w_data),
        .rd_en   (rd_accept_s),
        .rd_addr (rd_ptr_r),
        .rd_data (mem_rd_data_s)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (default 8 x 16 configuration).
// Build with SYNC_FIFO_HALFFULL_EN defined to also exercise half_full.
module tb_sync_fifo;

    logic       clk;
    logic       reset;
    logic       w_enable;
    logic       r_enable;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       full;
    logic       empty;
`ifdef SYNC_FIFO_HALFFULL_EN
    logic       half_full;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sync_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .w_enable (w_enable),
        .r_enable (r_enable),
        .w_data   (w_data),
        .r_data   (r_data),
        .full     (full),
        .empty    (empty)
`ifdef SYNC_FIFO_HALFFULL_EN
        ,
        .half_full(half_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        w_enable = 1'b0;
        r_enable = 1'b0;
        w_data   = 8'h00;

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #1;
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_rdata", 32'(r_data), 32'h00);
`ifdef SYNC_FIFO_HALFFULL_EN
        check_val("rst_hf", 32'(half_full), 32'd0);
`endif
        #8 reset = 1'b1;
        tick();
        check_val("idle_empty", 32'(empty), 32'd1);
        check_val("idle_full", 32'(full), 32'd0);
        check_val("idle_rdata", 32'(r_data), 32'h00);

        // Fill with 0x00..0x0F.
        w_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_data = 8'(i);
            tick();
            check_val($sformatf("fill_full_%0d", i), 32'(full), (i == 15) ? 32'd1 : 32'd0);
            check_val($sformatf("fill_empty_%0d", i), 32'(empty), 32'd0);
`ifdef SYNC_FIFO_HALFFULL_EN
            check_val($sformatf("fill_hf_%0d", i), 32'(half_full), (i >= 7) ? 32'd1 : 32'd0);
`endif
        end
        // Overflow attempt is dropped.
        w_data = 8'hAA;
        tick();
        check_val("ovf_count", 32'(dut.count_r), 32'd16);
        check_val("ovf_full", 32'(full), 32'd1);
        check_val("ovf_rdata", 32'(r_data), 32'h00);
        w_enable = 1'b0;

        // Drain in order, then underflow attempt.
        r_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_val($sformatf("drain_data_%0d", i), 32'(r_data), 32'(i));
            check_val($sformatf("drain_empty_%0d", i), 32'(empty), (i == 15) ? 32'd1 : 32'd0);
        end
        tick();
        check_val("udf_rdata", 32'(r_data), 32'h0F);
        check_val("udf_count", 32'(dut.count_r), 32'd0);
        r_enable = 1'b0;

        // Preload 8 entries 0x20..0x27, then 16 simultaneous cycles across wrap.
        w_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_data = 8'h20 + 8'(i);
            tick();
        end
        r_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_data = 8'h28 + 8'(i);
            tick();
            check_val($sformatf("rw_data_%0d", i), 32'(r_data), 32'h20 + 32'(i));
            check_val($sformatf("rw_count_%0d", i), 32'(dut.count_r), 32'd8);
        end
        w_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val($sformatf("tail_data_%0d", i), 32'(r_data), 32'h30 + 32'(i));
        end
        check_val("tail_empty", 32'(empty), 32'd1);
        r_enable = 1'b0;

        // Simultaneous read and write while full: read only.
        w_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_data = 8'h40 + 8'(i);
            tick();
        end
        check_val("full2_full", 32'(full), 32'd1);
        w_data   = 8'hBB;
        r_enable = 1'b1;
        tick();
        check_val("fullrw_rdata", 32'(r_data), 32'h40);
        check_val("fullrw_full", 32'(full), 32'd0);
        check_val("fullrw_count", 32'(dut.count_r), 32'd15);
        w_enable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_val($sformatf("fullrw_data_%0d", i), 32'(r_data), 32'h41 + 32'(i));
        end
        check_val("fullrw_empty", 32'(empty), 32'd1);

        // Simultaneous read and write while empty: write only.
        w_enable = 1'b1;
        w_data   = 8'h55;
        tick();
        check_val("emptyrw_empty", 32'(empty), 32'd0);
        check_val("emptyrw_count", 32'(dut.count_r), 32'd1);
        check_val("emptyrw_rdata", 32'(r_data), 32'h4F);
        w_enable = 1'b0;
        tick();
        check_val("emptyrw_read", 32'(r_data), 32'h55);
        check_val("emptyrw_empty2", 32'(empty), 32'd1);
        r_enable = 1'b0;

        // Asynchronous reset with 5 entries stored.
        w_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_data = 8'h60 + 8'(i);
            tick();
        end
        w_enable = 1'b0;
        check_val("pre_rst_count", 32'(dut.count_r), 32'd5);
        reset = 1'b0;
        #2;
        check_val("arst_empty", 32'(empty), 32'd1);
        check_val("arst_full", 32'(full), 32'd0);
        check_val("arst_rdata", 32'(r_data), 32'h00);
        check_val("arst_count", 32'(dut.count_r), 32'd0);
        #2 reset = 1'b1;

        // First edge after release operates normally; stale entries are gone.
        w_enable = 1'b1;
        w_data   = 8'h70;
        tick();
        check_val("post_count", 32'(dut.count_r), 32'd1);
        check_val("post_empty", 32'(empty), 32'd0);
        w_enable = 1'b0;
        r_enable = 1'b1;
        tick();
        check_val("post_rdata", 32'(r_data), 32'h70);
        check_val("post_empty2", 32'(empty), 32'd1);
        r_enable = 1'b0;

`ifdef SYNC_FIFO_HALFFULL_EN
        // half_full rises on the 8th write and falls on reset.
        w_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_data = 8'h80 + 8'(i);
            tick();
            check_val($sformatf("hf2_%0d", i), 32'(half_full), (i == 7) ? 32'd1 : 32'd0);
        end
        w_enable = 1'b0;
        reset = 1'b0;
        #2;
        check_val("hf_rst", 32'(half_full), 32'd0);
        check_val("hf_rst_empty", 32'(empty), 32'd1);
        #2 reset = 1'b1;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two ≥ 2.
REQ-003 Derived constant ADDR_WIDTH = log2(DEPTH), default 4: pointer width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 w_enable  input  1  write request.
REQ-007 r_enable  input  1  read request.
REQ-008 w_data  input  DATA_WIDTH  write data, sampled on the rising clk edge when a write is accepted.
REQ-009 r_data  output  DATA_WIDTH  registered read data.
REQ-010 full  output  1  high when the FIFO holds DEPTH entries.
REQ-011 empty  output  1  high when the FIFO holds 0 entries.
REQ-012 half_full  output  1  present only with SYNC_FIFO_HALFFULL_EN; high when count ≥ DEPTH/2.

Function
REQ-013 Write accepted iff w_enable=1 and full=0 at the rising edge: w_data stored at the write pointer, which then increments modulo DEPTH.
REQ-014 Read accepted iff r_enable=1 and empty=0 at the rising edge: the entry at the read pointer is loaded into r_data on that edge, and the read pointer increments modulo DEPTH.
REQ-015 Read latency is one cycle: r_data is valid after the edge that accepts the read; r_data holds its last value when no read is accepted.
REQ-016 An occupancy count of ADDR_WIDTH+1 bits: +1 on write-only, −1 on read-only, unchanged on both or neither.
REQ-017 full = (count == DEPTH); empty = (count == 0); both are combinational decodes of registered state, so there are no glitch paths from inputs.
REQ-018 Simultaneous read and write when neither flag is set: both are accepted in the same cycle and count is unchanged.
REQ-019 When full=1, a write is dropped even if a read is accepted in the same cycle; only the read proceeds.
REQ-020 When empty=1, a read is ignored (r_data unchanged); a simultaneous write is accepted.
REQ-021 Overflow and underflow attempts SHALL NOT alter pointers, count, memory or r_data.
REQ-022 Data SHALL emerge in strict write order across pointer wrap-around.

Reset
REQ-023 reset=0 immediately, without waiting for clk, clears both pointers, count and r_data to 0, giving empty=1, full=0 and half_full=0.
REQ-024 Memory contents are not reset.
REQ-025 Reset asserted mid-operation discards all stored entries.
REQ-026 The first edge after reset is released SHALL operate normally.

Configuration
REQ-027 With macro SYNC_FIFO_HALFFULL_EN defined, the half_full port and its logic (REQ-012) are compiled in.
REQ-028 Without SYNC_FIFO_HALFFULL_EN, the half_full port is absent and all other behaviour is identical.

Structure
REQ-029 Shared package sync_fifo_pkg holds the DATA_WIDTH and DEPTH defaults and the ADDR_WIDTH derivation function/constant.
REQ-030 Storage is a sub-module sync_fifo_mem with one synchronous write port and one synchronous read port, and no reset; pointer, count and flag control stays in sync_fifo.

Verification
REQ-031 Reset pulse, then idle → empty=1, full=0, r_data=0x00.
REQ-032 Write 0x00..0x0F on 16 consecutive cycles → full=1 after the 16th edge; a 17th write of 0xAA is dropped and count stays 16.
REQ-033 From full, read 16 cycles → r_data=0x00..0x0F in order, one cycle after each accepted read; empty=1 after the 16th read; a 17th read leaves r_data=0x0F.
REQ-034 Simultaneous read and write with 8 entries → count stays 8; data order is preserved across pointer wrap (write 24 and read 24 total values in order).
REQ-035 Simultaneous read and write while full → read accepted, write dropped, full deasserts; while empty → write accepted, empty deasserts.
REQ-036 Assert reset asynchronously with 5 entries stored → empty=1 before the next clk edge; with SYNC_FIFO_HALFFULL_EN, half_full rises on the 8th write and falls on the reset.
